// File: rtl/trap_unit.sv
// Trap unit: privilege mode, machine trap CSRs, trap entry and xRET with a one-cycle redirect.
// Optional supervisor support (S CSRs, medeleg delegation, sret) is built when SMODE_EN is defined.
module trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            raise_excep,
    input  logic [3:0]      excep_code,
    input  logic            ret,
    input  logic [1:0]      ret_from,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] tval,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic [1:0]      mode,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);
    localparam logic [1:0]      PRIV_U     = 2'd0;
    localparam logic [1:0]      PRIV_M     = 2'd3;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
`ifdef SMODE_EN
    localparam logic [1:0]  PRIV_S       = 2'd1;
    localparam logic [11:0] ADDR_STVEC   = 12'h105;
    localparam logic [11:0] ADDR_SEPC    = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
    localparam logic [11:0] ADDR_STVAL   = 12'h143;
    localparam logic [11:0] ADDR_MEDELEG = 12'h302;
`endif

    typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
    state_t state, next_state;

    logic            sie, mie, spie, mpie, spp;
    logic [1:0]      mpp;
    logic [XLEN-1:0] mtvec, mepc, mtval;
    logic [3:0]      mcause;
`ifdef SMODE_EN
    logic [XLEN-1:0] stvec, sepc, stval;
    logic [3:0]      scause;
    logic [15:0]     medeleg;
    logic            trap_deleg, lat_deleg, lat_sret;
`endif

    logic [XLEN-1:0] lat_pc, lat_tval, lat_target;
    logic [3:0]      lat_code;
    logic            req, ret_ok, take_trap, take_ret, csr_write;
    logic [3:0]      trap_code;
    logic [XLEN-1:0] trap_tval, trap_target;

    // Unsupported xRET flavours become an illegal-instruction trap (code 2) to mtvec.
    assign req       = (state == IDLE) && valid && (raise_excep || ret);
    assign take_trap = req && (raise_excep || !ret_ok);
    assign take_ret  = req && !take_trap;
    assign csr_write = (state == IDLE) && csr_we && !req;
    assign trap_code = raise_excep ? excep_code : 4'd2;
    assign trap_tval = raise_excep ? tval : '0;

    always_comb begin
        ret_ok      = (ret_from == PRIV_M);
        trap_target = mtvec;
`ifdef SMODE_EN
        ret_ok      = ret_ok || (ret_from == PRIV_S);
        trap_deleg  = raise_excep && (mode != PRIV_M) && medeleg[excep_code];
        if (trap_deleg) trap_target = stvec;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        if (take_trap)     next_state = TRAP;
        else if (take_ret) next_state = RET;
    end

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        busy        = req;
        case (state)
            TRAP: begin
                redirect    = 1'b1;
                busy        = 1'b1;
                redirect_pc = lat_target;
            end
            RET: begin
                redirect    = 1'b1;
                busy        = 1'b1;
                redirect_pc = mepc;
`ifdef SMODE_EN
                if (lat_sret) redirect_pc = sepc;
`endif
            end
            default: ;
        endcase
    end

    // The request is captured at acceptance so the TRAP cycle does not depend on held inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_pc     <= '0;
            lat_tval   <= '0;
            lat_target <= '0;
            lat_code   <= '0;
`ifdef SMODE_EN
            lat_deleg  <= 1'b0;
            lat_sret   <= 1'b0;
`endif
        end else if (take_trap) begin
            lat_pc     <= pc;
            lat_tval   <= trap_tval;
            lat_target <= trap_target;
            lat_code   <= trap_code;
`ifdef SMODE_EN
            lat_deleg  <= trap_deleg;
        end else if (take_ret) begin
            lat_sret   <= (ret_from == PRIV_S);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= PRIV_M;
            {sie, mie, spie, mpie, spp} <= '0;
            mpp    <= PRIV_U;
            mtvec  <= MTVEC_RESET & ALIGN_MASK;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
`ifdef SMODE_EN
            stvec   <= '0;
            sepc    <= '0;
            scause  <= '0;
            stval   <= '0;
            medeleg <= '0;
`endif
        end else begin
            case (state)
                TRAP: begin
`ifdef SMODE_EN
                    if (lat_deleg) begin
                        sepc   <= lat_pc & ALIGN_MASK;
                        scause <= lat_code;
                        stval  <= lat_tval;
                        spie   <= sie;
                        sie    <= 1'b0;
                        spp    <= mode[0];
                        mode   <= PRIV_S;
                    end else begin
                        mepc   <= lat_pc & ALIGN_MASK;
                        mcause <= lat_code;
                        mtval  <= lat_tval;
                        mpie   <= mie;
                        mie    <= 1'b0;
                        mpp    <= mode;
                        mode   <= PRIV_M;
                    end
`else
                    mepc   <= lat_pc & ALIGN_MASK;
                    mcause <= lat_code;
                    mtval  <= lat_tval;
                    mpie   <= mie;
                    mie    <= 1'b0;
                    mpp    <= mode;
                    mode   <= PRIV_M;
`endif
                end
                RET: begin
`ifdef SMODE_EN
                    if (lat_sret) begin
                        mode <= {1'b0, spp};
                        sie  <= spie;
                        spie <= 1'b1;
                        spp  <= 1'b0;
                    end else begin
                        mode <= mpp;
                        mie  <= mpie;
                        mpie <= 1'b1;
                        mpp  <= PRIV_U;
                    end
`else
                    mode <= mpp;
                    mie  <= mpie;
                    mpie <= 1'b1;
                    mpp  <= PRIV_U;
`endif
                end
                default: begin
                    if (csr_write) begin
                        case (csr_addr)
                            ADDR_MSTATUS: begin
                                sie  <= csr_wdata[1];
                                mie  <= csr_wdata[3];
                                spie <= csr_wdata[5];
                                mpie <= csr_wdata[7];
                                spp  <= csr_wdata[8];
                                mpp  <= csr_wdata[12:11];
                            end
                            ADDR_MTVEC:   mtvec  <= csr_wdata & ALIGN_MASK;
                            ADDR_MEPC:    mepc   <= csr_wdata & ALIGN_MASK;
                            ADDR_MCAUSE:  mcause <= csr_wdata[3:0];
                            ADDR_MTVAL:   mtval  <= csr_wdata;
`ifdef SMODE_EN
                            ADDR_STVEC:   stvec   <= csr_wdata & ALIGN_MASK;
                            ADDR_SEPC:    sepc    <= csr_wdata & ALIGN_MASK;
                            ADDR_SCAUSE:  scause  <= csr_wdata[3:0];
                            ADDR_STVAL:   stval   <= csr_wdata;
                            ADDR_MEDELEG: medeleg <= csr_wdata[15:0];
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[1]     = sie;
                csr_rdata[3]     = mie;
                csr_rdata[5]     = spie;
                csr_rdata[7]     = mpie;
                csr_rdata[8]     = spp;
                csr_rdata[12:11] = mpp;
            end
            ADDR_MTVEC:   csr_rdata      = mtvec;
            ADDR_MEPC:    csr_rdata      = mepc;
            ADDR_MCAUSE:  csr_rdata[3:0] = mcause;
            ADDR_MTVAL:   csr_rdata      = mtval;
`ifdef SMODE_EN
            ADDR_STVEC:   csr_rdata       = stvec;
            ADDR_SEPC:    csr_rdata       = sepc;
            ADDR_SCAUSE:  csr_rdata[3:0]  = scause;
            ADDR_STVAL:   csr_rdata       = stval;
            ADDR_MEDELEG: csr_rdata[15:0] = medeleg;
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios plus random traffic against a CSR-level model.
// Follows the SMODE_EN setting of the build for its model.
module tb_trap_unit;
    localparam int XLEN = 32;
`ifdef SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, raise_excep, ret, csr_we;
    logic [3:0]  excep_code;
    logic [1:0]  ret_from;
    logic [31:0] pc, tval, csr_wdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, redirect_pc;
    logic [1:0]  mode;
    logic        redirect, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_unit #(.XLEN(XLEN), .MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .valid(valid), .raise_excep(raise_excep),
        .excep_code(excep_code), .ret(ret), .ret_from(ret_from), .pc(pc),
        .tval(tval), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .mode(mode), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    // Architectural model of the privilege state and trap CSRs
    bit          m_sie, m_mie, m_spie, m_mpie, m_spp;
    logic [1:0]  m_mpp, m_mode;
    logic [31:0] m_mtvec, m_mepc, m_mtval, m_stvec, m_sepc, m_stval;
    logic [3:0]  m_mcause, m_scause;
    logic [15:0] m_medeleg;

    logic [11:0] addr_list [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h105,
                                    12'h141, 12'h142, 12'h143, 12'h302, 12'h340, 12'h000};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        {m_sie, m_mie, m_spie, m_mpie, m_spp} = '0;
        m_mpp = 2'd0;  m_mode = 2'd3;
        m_mtvec = 32'h100; m_mepc = 0; m_mtval = 0; m_mcause = 0;
        m_stvec = 0; m_sepc = 0; m_stval = 0; m_scause = 0; m_medeleg = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        logic [31:0] r;
        r = 0;
        case (a)
            12'h300: r = (32'(m_sie) << 1) | (32'(m_mie) << 3) | (32'(m_spie) << 5) |
                         (32'(m_mpie) << 7) | (32'(m_spp) << 8) | (32'(m_mpp) << 11);
            12'h305: r = m_mtvec;
            12'h341: r = m_mepc;
            12'h342: r = 32'(m_mcause);
            12'h343: r = m_mtval;
            12'h105: r = SMODE ? m_stvec : 32'h0;
            12'h141: r = SMODE ? m_sepc : 32'h0;
            12'h142: r = SMODE ? 32'(m_scause) : 32'h0;
            12'h143: r = SMODE ? m_stval : 32'h0;
            12'h302: r = SMODE ? 32'(m_medeleg) : 32'h0;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic modelWrite(input logic [11:0] a, input logic [31:0] w);
        case (a)
            12'h300: begin
                m_sie = w[1]; m_mie = w[3]; m_spie = w[5]; m_mpie = w[7]; m_spp = w[8]; m_mpp = w[12:11];
            end
            12'h305: m_mtvec = w & ~32'h3;
            12'h341: m_mepc = w & ~32'h3;
            12'h342: m_mcause = w[3:0];
            12'h343: m_mtval = w;
            12'h105: if (SMODE) m_stvec = w & ~32'h3;
            12'h141: if (SMODE) m_sepc = w & ~32'h3;
            12'h142: if (SMODE) m_scause = w[3:0];
            12'h143: if (SMODE) m_stval = w;
            12'h302: if (SMODE) m_medeleg = w[15:0];
            default: ;
        endcase
    endtask

    function automatic bit modelDeleg(input logic [3:0] c);
        return SMODE && (m_mode != 2'd3) && m_medeleg[c];
    endfunction

    function automatic logic [31:0] modelTarget(input bit re, input logic [3:0] c, input logic [1:0] rf);
        if (re)                return modelDeleg(c) ? m_stvec : m_mtvec;
        if (rf == 2'd3)        return m_mepc;
        if (rf == 2'd1 && SMODE) return m_sepc;
        return m_mtvec;
    endfunction

    task automatic modelEnterTrap(input logic [3:0] c, input logic [31:0] p, input logic [31:0] t, input bit d);
        if (d) begin
            m_sepc = p & ~32'h3; m_scause = c; m_stval = t;
            m_spie = m_sie; m_sie = 0; m_spp = m_mode[0]; m_mode = 2'd1;
        end else begin
            m_mepc = p & ~32'h3; m_mcause = c; m_mtval = t;
            m_mpie = m_mie; m_mie = 0; m_mpp = m_mode; m_mode = 2'd3;
        end
    endtask

    task automatic modelApply(input bit re, input logic [3:0] c, input logic [1:0] rf,
                              input logic [31:0] p, input logic [31:0] t);
        if (re) modelEnterTrap(c, t == t ? p : p, t, modelDeleg(c));
        else if (rf == 2'd3) begin
            m_mode = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'd0;
        end else if (rf == 2'd1 && SMODE) begin
            m_mode = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1; m_spp = 0;
        end else modelEnterTrap(4'd2, p, 32'h0, 1'b0);
    endtask

    function automatic logic [11:0] pickAddr();
        return addr_list[$urandom_range(0, 11)];
    endfunction

    task automatic driveIdle();
        valid = 0; raise_excep = 0; ret = 0; csr_we = 0;
        excep_code = 0; ret_from = 0; pc = 0; tval = 0; csr_wdata = 0;
    endtask

    // One commit-cycle transaction; a request also covers its redirect cycle with junk inputs.
    task automatic applyStimulus(input bit v, input bit re, input logic [3:0] c, input bit rt,
                                 input logic [1:0] rf, input logic [31:0] p, input logic [31:0] t,
                                 input bit we, input logic [11:0] a, input logic [31:0] wd);
        bit          req;
        logic [31:0] target;
        @(negedge clk);
        valid = v; raise_excep = re; excep_code = c; ret = rt; ret_from = rf;
        pc = p; tval = t; csr_we = we; csr_addr = a; csr_wdata = wd;
        #1;
        req = v && (re || rt);
        checkOutput("busy_request", 32'(busy), 32'(req));
        checkOutput("redirect_idle", 32'(redirect), 0);
        checkOutput("redirect_pc_idle", redirect_pc, 0);
        checkOutput("mode", 32'(mode), 32'(m_mode));
        checkOutput("rdata_idle", csr_rdata, modelRead(a));
        if (req) begin
            target = modelTarget(re, c, rf);
            @(negedge clk);
            valid = 1; raise_excep = 1'($urandom_range(0, 1)); ret = 1'($urandom_range(0, 1));
            excep_code = 4'($urandom); ret_from = 2'($urandom); pc = $urandom; tval = $urandom;
            csr_we = 1; csr_addr = pickAddr(); csr_wdata = $urandom;
            #1;
            checkOutput("redirect_pulse", 32'(redirect), 1);
            checkOutput("busy_pulse", 32'(busy), 1);
            checkOutput("redirect_pc", redirect_pc, target);
            checkOutput("rdata_busy", csr_rdata, modelRead(csr_addr));
            modelApply(re, c, rf, p, t);
            @(negedge clk);
            driveIdle();
        end else if (we) begin
            modelWrite(a, wd);
        end
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] a, input logic [31:0] expected);
        @(negedge clk);
        driveIdle();
        csr_addr = a;
        #1;
        checkOutput(tag, csr_rdata, expected);
    endtask

    task automatic checkAllCsrs();
        foreach (addr_list[k]) checkCsr($sformatf("csr_%h", addr_list[k]), addr_list[k], modelRead(addr_list[k]));
        checkOutput("mode_sweep", 32'(mode), 32'(m_mode));
    endtask

    initial begin
        driveIdle();
        csr_addr = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        modelReset();
        #1;
        checkOutput("reset_mode", 32'(mode), 3);
        checkOutput("reset_redirect", 32'(redirect), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_redirect_pc", redirect_pc, 0);
        checkCsr("reset_mtvec", 12'h305, 32'h100);
        checkCsr("reset_mstatus", 12'h300, 32'h0);

        // mtvec write, then ecall from M
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h2003);
        checkCsr("mtvec_aligned", 12'h305, 32'h2000);
        applyStimulus(1, 1, 4'd11, 0, 0, 32'h40, 32'h0, 0, 12'h305, 0);
        checkCsr("ecall_mepc", 12'h341, 32'h40);
        checkCsr("ecall_mcause", 12'h342, 32'd11);
        checkCsr("ecall_mstatus", 12'h300, 32'h1800);

        // mret to U with MPIE set
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h80);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h44);
        applyStimulus(1, 0, 0, 1, 2'd3, 32'h90, 0, 0, 12'h341, 0);
        checkCsr("mret_mstatus", 12'h300, 32'h88);
        checkOutput("mret_mode", 32'(mode), 0);

        // trap beats ret and csr_we in the same cycle
        applyStimulus(1, 1, 4'd2, 1, 2'd3, 32'h60, 32'h5, 1, 12'h305, 32'hdead0000);
        checkCsr("prio_mtvec", 12'h305, 32'h2000);
        checkCsr("prio_mcause", 12'h342, 32'd2);
        checkOutput("prio_mode", 32'(mode), 3);

        // delegation of ecall-from-U when S mode is built
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h302, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h105, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h50);
        applyStimulus(1, 0, 0, 1, 2'd3, 32'h0, 0, 0, 12'h300, 0);
        applyStimulus(1, 1, 4'd8, 0, 0, 32'h80, 32'h0, 0, 12'h300, 0);
        checkCsr("deleg_sepc", 12'h141, SMODE ? 32'h80 : 32'h0);
        checkCsr("deleg_mepc", 12'h341, SMODE ? 32'h50 : 32'h80);
        checkOutput("deleg_mode", 32'(mode), SMODE ? 32'd1 : 32'd3);

        // unsupported uret becomes an illegal-instruction trap
        applyStimulus(1, 0, 0, 1, 2'd0, 32'hA4, 32'h0, 0, 12'h342, 0);
        checkCsr("uret_mcause", 12'h342, 32'd2);
        checkCsr("uret_mepc", 12'h341, 32'hA4);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4)
                applyStimulus(0, 1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                              1, pickAddr(), $urandom);
            else if (kind < 6)
                applyStimulus(1, 1, 4'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                              1'($urandom), pickAddr(), $urandom);
            else if (kind < 8)
                applyStimulus(1, 0, 4'($urandom), 1, 2'($urandom), $urandom, $urandom,
                              1'($urandom), pickAddr(), $urandom);
            else
                applyStimulus(1, 0, 0, 0, 0, $urandom, $urandom, 1, pickAddr(), $urandom);
            if (i % 5 == 4) checkAllCsrs();
        end
        checkAllCsrs();

        // reset asserted during the TRAP cycle
        @(negedge clk);
        driveIdle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        modelReset();
        valid = 1; raise_excep = 1; excep_code = 4'd5; pc = 32'h90; tval = 32'h33;
        @(negedge clk);
        driveIdle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        checkOutput("rst_trap_redirect", 32'(redirect), 0);
        checkOutput("rst_trap_busy", 32'(busy), 0);
        checkOutput("rst_trap_mode", 32'(mode), 3);
        checkCsr("rst_trap_mepc", 12'h341, 32'h0);
        checkCsr("rst_trap_mcause", 12'h342, 32'h0);
        checkOutput("rst_trap_redirect_after", 32'(redirect), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Responder for the decoder's exception/return request lines (RaiseExcep, ExcepCode, Ret, RetFrom).
- Owns privilege mode and the trap CSRs. Performs trap entry and xRET at commit, and drives a one-cycle PC redirect with a pipeline stall.
- Sits beside the PC/fetch logic; the CSR execute path reads and writes through its CSR port.

Parameters:
- XLEN, 32, datapath width.
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- valid  in  1  instruction at commit this cycle; all request inputs ignored when 0
- raise_excep  in  1  exception request from decoder
- excep_code  in  4  exception cause code
- ret  in  1  xRET request
- ret_from  in  2  privilege of xRET: USER=0, SUPERV=1, MACHINE=3 (defines.vh)
- pc  in  XLEN  PC of committing instruction
- tval  in  XLEN  trap value (0 for ecall)
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address, read and write
- csr_wdata  in  XLEN  CSR write data
- csr_rdata  out  XLEN  combinational read of csr_addr; unimplemented addresses read 0
- mode  out  2  current privilege
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  redirect target
- busy  out  1  stall request while FSM is not IDLE

Behaviour:
- Reset state: mode=MACHINE, mstatus=0, mtvec=MTVEC_RESET, mepc=mcause=mtval=0, S CSRs=0, FSM=IDLE, redirect=0, redirect_pc=0, busy=0.
- CSRs and addresses:
  - mstatus 0x300: SIE b1, MIE b3, SPIE b5, MPIE b7, SPP b8, MPP b12:11; other bits read 0.
  - mtvec 0x305: direct mode only; bits 1:0 forced to 0.
  - mepc 0x341: bits 1:0 forced to 0.
  - mcause 0x342: holds zero-extended excep_code, bit XLEN-1 = 0.
  - mtval 0x343.
- FSM states: IDLE, TRAP, RET.
  - IDLE with valid & raise_excep: latch pc, excep_code, tval and target, then go to TRAP.
  - Otherwise, IDLE with valid & ret: go to RET.
  - Otherwise, IDLE with csr_we: write takes effect at that clock edge.
- Priority within one cycle: raise_excep > ret > csr_we. The losing request is dropped.
- TRAP (exactly one cycle): redirect=1, busy=1, redirect_pc=target vector. At the end of the cycle:
  - mepc <= pc, mcause <= code, mtval <= tval
  - MPIE <= MIE, MIE <= 0, MPP <= mode, mode <= MACHINE
  - go to IDLE.
- RET (exactly one cycle): redirect=1, busy=1.
  - ret_from=MACHINE: redirect_pc=mepc; mode <= MPP, MIE <= MPIE, MPIE <= 1, MPP <= USER.
  - ret_from=USER: unsupported; handled as a trap with code 2, tval=0 (target mtvec, mepc <= pc).
  - ret_from=SUPERV: see Optional Feature.
- Latency: request accepted at edge N; redirect and busy high during cycle N+1; new mode visible from N+2.
- busy is also high in cycle N (combinational from valid & (raise_excep | ret) in IDLE), so fetch freezes immediately.
- csr_we, raise_excep and ret are ignored while not IDLE.
- Reset asserted in TRAP or RET: no CSR/mode update, FSM goes to IDLE, redirect=0 next cycle.
- Mode legality (e.g. mret from U) is decided upstream; this block trusts the request lines.

Optional Feature:
- Macro: SMODE_EN.
- Defined:
  - Adds stvec 0x105, sepc 0x141, scause 0x142, stval 0x143 and medeleg 0x302 (bits 15:0 writable).
  - Trap with mode != MACHINE and medeleg[code]=1 goes to S: sepc/scause/stval written, SPIE <= SIE, SIE <= 0, SPP <= mode[0], mode <= SUPERV, redirect_pc = stvec.
  - sret (ret_from=SUPERV): redirect_pc = sepc, mode <= {1'b0,SPP}, SIE <= SPIE, SPIE <= 1, SPP <= 0.
- Undefined:
  - Those CSRs read 0 and ignore writes; all traps go to M.
  - sret is handled as a trap with code 2.

Test Plan:
- Reset -> mode=3, csr_rdata(0x305)=0x100, redirect=0, busy=0.
- Write mtvec=0x2003, then ecall (code 11, pc=0x40) in M -> next cycle redirect=1, redirect_pc=0x2000; then mepc=0x40, mcause=11, MPP=3, MIE=0.
- mstatus: MPP=0, MPIE=1; mepc=0x44; mret -> redirect_pc=0x44, mode=0, MIE=1, MPIE=1, MPP=0.
- raise_excep=1 (code 2) and ret=1 in the same cycle, with csr_we to mtvec -> trap only; mtvec unchanged, mcause=2.
- SMODE_EN defined, medeleg=0x100, mode=U, ecall code 8 at pc 0x80 -> redirect_pc=stvec, sepc=0x80, mode=1, mepc unchanged. Undefined -> redirect_pc=mtvec.
- rst pulsed during the TRAP cycle -> mepc/mcause unchanged from reset, mode=3, FSM IDLE, no redirect afterwards.
